// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Round-robin arbiter that shares one req/gnt/rvalid memory slave port between
// NB_MASTER requesters. Arbitration is zero-latency: the grant returns in the
// same cycle as the request. A request stalled by the slave is locked, so its
// master, address and data stay stable until the slave grants it. Each accepted
// transaction (read or write) pushes the granted master's ID into a small FIFO.
// The slave's in-order rvalid pops that FIFO to route the response back.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   m_req_i/m_gnt_o   : per-master request / same-cycle grant (one-hot or zero)
//   m_addr_i/m_we_i/m_be_i/m_wdata_i : per-master request payload, slice k = master k
//   m_rvalid_o        : per-master response valid (one-hot or zero)
//   m_rdata_o         : response data, broadcast to all masters
//   s_req_o/s_gnt_i   : slave request / grant
//   s_addr_o/s_we_o/s_be_o/s_wdata_o : payload of the selected master
//   s_rvalid_i/s_rdata_i : in-order slave response
//   err_o             : sticky protocol error (orphan rvalid, or a locked master
//                       withdrawing its request), cleared only by rst
module mem_port_arbiter #(
  parameter int NB_MASTER       = 3,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NB_MASTER-1:0]            m_req_i,
  input  logic [NB_MASTER*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NB_MASTER-1:0]            m_we_i,
  input  logic [NB_MASTER*DATA_WIDTH/8-1:0] m_be_i,
  input  logic [NB_MASTER*DATA_WIDTH-1:0] m_wdata_i,
  output logic [NB_MASTER-1:0]            m_gnt_o,
  output logic [NB_MASTER-1:0]            m_rvalid_o,
  output logic [DATA_WIDTH-1:0]           m_rdata_o,
  output logic                            s_req_o,
  output logic [ADDR_WIDTH-1:0]           s_addr_o,
  output logic                            s_we_o,
  output logic [DATA_WIDTH/8-1:0]         s_be_o,
  output logic [DATA_WIDTH-1:0]           s_wdata_o,
  input  logic                            s_gnt_i,
  input  logic                            s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]           s_rdata_i,
  output logic                            err_o
);

  localparam int ID_W  = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  // FIFO pointer increment that wraps at MAX_OUTSTANDING (need not fill PTR_W)
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  // Master ID increment modulo NB_MASTER
  function automatic logic [ID_W-1:0] id_inc(input logic [ID_W-1:0] id);
    if (id == ID_W'(NB_MASTER - 1)) begin
      id_inc = '0;
    end else begin
      id_inc = id + ID_W'(1);
    end
  endfunction

  lock_state_e      state_r, state_nxt_s;
  logic [ID_W-1:0]  locked_id_r, locked_id_nxt_s;
  logic [ID_W-1:0]  rr_ptr_r;
  logic [ID_W-1:0]  sel_s;
  logic             found_s;
  logic             req_sel_s;
  logic             s_req_s;
  logic             accept_s;
  logic             lock_err_s;
  logic [ADDR_WIDTH-1:0] addr_sel_s;
  logic             we_sel_s;
  logic [BE_W-1:0]  be_sel_s;
  logic [DATA_WIDTH-1:0] wdata_sel_s;

  logic [ID_W-1:0]  fifo_mem_r [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             fifo_full_s;
  logic             push_s, pop_s;
  logic [ID_W-1:0]  head_s;
  logic             err_r;

  // Master selection: the locked master, else first requester at or after rr_ptr, wrapping
  always_comb begin
    sel_s   = rr_ptr_r;
    found_s = 1'b0;
    if (state_r == ST_LOCKED) begin
      sel_s = locked_id_r;
    end else begin
      // First pass covers rr_ptr..NB_MASTER-1, second pass the wrapped part 0..rr_ptr-1.
      for (int k = 0; k < NB_MASTER; k++) begin
        if (!found_s && m_req_i[k] && (ID_W'(k) >= rr_ptr_r)) begin
          sel_s   = ID_W'(k);
          found_s = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
      for (int k = 0; k < NB_MASTER; k++) begin
        if (!found_s && m_req_i[k]) begin
          sel_s   = ID_W'(k);
          found_s = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // Request payload mux from the selected master
  always_comb begin
    req_sel_s   = 1'b0;
    addr_sel_s  = '0;
    we_sel_s    = 1'b0;
    be_sel_s    = '0;
    wdata_sel_s = '0;
    for (int k = 0; k < NB_MASTER; k++) begin
      if (sel_s == ID_W'(k)) begin
        req_sel_s   = m_req_i[k];
        addr_sel_s  = m_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        we_sel_s    = m_we_i[k];
        be_sel_s    = m_be_i[k*BE_W +: BE_W];
        wdata_sel_s = m_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        req_sel_s = req_sel_s;
      end
    end
  end

  // No full-bypass: a full FIFO blocks the request even if a pop happens this cycle
  assign fifo_full_s = (count_r == CNT_W'(MAX_OUTSTANDING));
  assign s_req_s     = !rst && req_sel_s && !fifo_full_s;
  assign accept_s    = s_req_s && s_gnt_i;
  assign push_s      = accept_s;
  assign pop_s       = s_rvalid_i && (count_r != '0);
  assign head_s      = fifo_mem_r[rd_ptr_r];

  // Lock FSM next state: a stalled request pins the selection until it is granted
  always_comb begin
    state_nxt_s     = state_r;
    locked_id_nxt_s = locked_id_r;
    lock_err_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (s_req_s && !s_gnt_i) begin
          state_nxt_s     = ST_LOCKED;
          locked_id_nxt_s = sel_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (accept_s) begin
          state_nxt_s = ST_IDLE;
        end else if (!req_sel_s) begin
          // Locked master withdrew its request before being granted.
          state_nxt_s = ST_IDLE;
          lock_err_s  = 1'b1;
        end else begin
          // Still waiting for the slave grant or for FIFO space.
          state_nxt_s = ST_LOCKED;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Lock FSM state register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      locked_id_r <= '0;
      rr_ptr_r    <= '0;
    end else begin
      state_r     <= state_nxt_s;
      locked_id_r <= locked_id_nxt_s;
      if (accept_s) begin
        rr_ptr_r <= id_inc(sel_s);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  // Response-routing ID FIFO: push the granted ID, pop on each in-order rvalid
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_mem_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= sel_s;
        wr_ptr_r             <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky error: orphan rvalid with an empty FIFO, or locked request withdrawn
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (lock_err_s || (s_rvalid_i && (count_r == '0))) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  // Output drive; everything is held at zero while rst is high
  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    for (int k = 0; k < NB_MASTER; k++) begin
      m_gnt_o[k]    = accept_s && (sel_s == ID_W'(k));
      m_rvalid_o[k] = !rst && pop_s && (head_s == ID_W'(k));
    end
    if (rst) begin
      m_rdata_o = '0;
      s_addr_o  = '0;
      s_we_o    = 1'b0;
      s_be_o    = '0;
      s_wdata_o = '0;
    end else begin
      m_rdata_o = s_rdata_i;
      s_addr_o  = addr_sel_s;
      s_we_o    = we_sel_s;
      s_be_o    = be_sel_s;
      s_wdata_o = wdata_sel_s;
    end
  end

  assign s_req_o = s_req_s;
  assign err_o   = err_r && !rst;

endmodule
